branch_pred_gshare: RTL and testbench
=====================================

# branch_pred_gshare

Parametrised dynamic branch predictor that generalises the fixed branch-condition predictor into a pattern-history table (PHT) of saturating counters with optional global-history (gshare) indexing. It sits beside the program counter and IF/ID stage. It produces a taken/not-taken prediction and a predicted next program counter for the branch currently in IF/ID. It is trained by branch resolution from EX, raises a one-cycle flush with a redirect address on misprediction, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- PROG_CTR_WID, 10, program counter width
- IDX_BITS, 4, PHT index width; the table has 2^IDX_BITS entries
- CTR_BITS, 2, saturating counter width (≥1)
- HIST_BITS, 0, global history register width; 0 = bimodal indexing, must be ≤ IDX_BITS
- STAT_WID, 16, statistics counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  branch instruction present in IF/ID
- lookup_pc  in  PROG_CTR_WID  PC of that branch
- lookup_target  in  PROG_CTR_WID  target address decoded from the branch instruction
- pred_taken  out  1  prediction for the current lookup
- pred_nxt_prog_ctr  out  PROG_CTR_WID  predicted next PC
- lookup_ghr  out  max(HIST_BITS,1)  history snapshot; the pipeline carries it to EX
- resolve_valid  in  1  branch resolved in EX this cycle
- resolve_pc  in  PROG_CTR_WID  PC of the resolved branch
- resolve_target  in  PROG_CTR_WID  actual branch target
- resolve_taken  in  1  actual outcome
- resolve_pred_taken  in  1  prediction made for this branch at lookup
- resolve_ghr  in  max(HIST_BITS,1)  lookup_ghr value carried with this branch
- flush  out  1  one-cycle misprediction pulse
- redirect_prog_ctr  out  PROG_CTR_WID  correct next PC, valid while flush=1
- branch_count  out  STAT_WID  resolved branches, saturating
- mispredict_count  out  STAT_WID  mispredictions, saturating

## Operation
- PHT index:
  - lookup: idx = lookup_pc[IDX_BITS-1:0] XOR zero-extended ghr
  - update: idx = resolve_pc[IDX_BITS-1:0] XOR zero-extended resolve_ghr
  - With HIST_BITS=0, the XOR term is 0 and lookup_ghr is driven 0.
- Prediction:
  - pred_taken = lookup_valid & counter MSB
  - pred_nxt_prog_ctr = pred_taken ? lookup_target : lookup_pc+1, truncated to PROG_CTR_WID, so 2^PROG_CTR_WID−1 wraps to 0
- Training on resolve_valid:
  - Taken: counter increments, saturating at 2^CTR_BITS−1.
  - Not taken: counter decrements, saturating at 0.
  - ghr ← {ghr[HIST_BITS-2:0], resolve_taken}. The history is non-speculative and updates at resolve only.
- Mispredict (resolve_valid & resolve_taken≠resolve_pred_taken):
  - Next cycle: flush=1.
  - redirect_prog_ctr = resolve_taken ? resolve_target : resolve_pc+1, with wrap.
- Statistics:
  - branch_count increments on every resolve_valid.
  - mispredict_count increments on every mispredict.
  - Both hold at all-ones.
- Simultaneous lookup and resolve, same index: the lookup sees the pre-update counter value and pre-update ghr.
- Back-to-back mispredicts produce back-to-back flush pulses, each with its own redirect.
- Resolve with lookup_valid=0 still trains the table.

## Timing
- Lookup path is combinational: pred_taken, pred_nxt_prog_ctr and lookup_ghr follow the lookup inputs and the current state in the same cycle.
- Table, ghr and statistics update on the edge that samples resolve_valid. The new value is visible to lookups from the next cycle.
- flush and redirect_prog_ctr are registered, one cycle after resolve.
  - flush is high for exactly one cycle per mispredict.
  - redirect_prog_ctr holds its last value when flush=0.
- Reset values:
  - every PHT counter = 2^(CTR_BITS-1)−1 (weakly not-taken; 1 for CTR_BITS=2, 0 for CTR_BITS=1)
  - ghr = 0
  - flush = 0
  - redirect_prog_ctr = 0
  - branch_count = 0
  - mispredict_count = 0
  - pred_taken = 0 (follows from the counter reset value)
  - pred_nxt_prog_ctr = lookup_pc+1
- Reset dominates: a resolve sampled in a reset cycle is discarded, with no training, no flush and no count. Reset mid-stream clears all state in one cycle.

## Structure
- Package bp_pkg holds:
  - function ctr_init(CTR_BITS)
  - function sat_update(ctr, taken, CTR_BITS)
  - localparam width helper for max(HIST_BITS,1)
- Sub-module bp_pht: 2^IDX_BITS × CTR_BITS register array with one asynchronous read port and one synchronous saturating-update port; reset is done inside it.
- Top level holds the index hashing, ghr, mispredict/redirect register and statistics counters.

## Test plan
Defaults unless stated: PROG_CTR_WID=10, IDX_BITS=4, CTR_BITS=2, HIST_BITS=0.
- Reset, then lookup pc=0x005, target=0x040 → pred_taken=0, pred_nxt_prog_ctr=0x006, flush=0, both counts=0.
- Resolve pc=0x005, taken=1, pred=0, target=0x040 → next cycle flush=1, redirect=0x040, mispredict_count=1. Second identical resolve with pred=1 → flush=0. Lookup 0x005 → pred_taken=1, pred_nxt_prog_ctr=0x040.
- Five taken resolves on 0x005, then one not-taken → counter 3 then 2, lookup still predicts taken; branch_count=6.
- Aliasing: train 0x005 taken ×2 → lookup 0x015 predicts taken. Repeat with HIST_BITS=4, resolve_ghr=4'b0001 → training lands on idx 4, so lookup 0x004 with ghr 0 predicts taken.
- Wrap: lookup pc=0x3FF not predicted → pred_nxt_prog_ctr=0x000. Not-taken mispredict at 0x3FF → redirect=0x000.
- Assert reset in the same cycle as a mispredicting resolve → no flush, counts 0, previously trained 0x005 predicts not-taken.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the gshare branch predictor: counter init/update rules and width helper.
package bp_pkg;

    // History register width; a zero-length history still needs a 1-bit port.
    function automatic int unsigned hist_width(int unsigned hist_bits);
        return (hist_bits == 0) ? 32'd1 : hist_bits;
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_init(int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Saturating up/down step of a ctr_bits-wide counter.
    function automatic int unsigned sat_update(int unsigned ctr, logic taken,
                                               int unsigned ctr_bits);
        int unsigned ctr_max;
        ctr_max = (32'd1 << ctr_bits) - 32'd1;
        if (taken) begin
            return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern-history table: array of saturating counters, async read, sync train.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] table_q [ENTRIES];

    // Lookup sees the pre-update contents; training lands on the clock edge.
    assign rd_ctr = table_q[rd_idx];

    // Reset every entry, otherwise apply one saturating step to the trained entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_RST;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= CTR_BITS'(sat_update(32'(table_q[wr_idx]), wr_taken, CTR_BITS));
        end
    end

endmodule

// File: rtl/branch_pred_gshare.sv
// Gshare/bimodal branch predictor: index hashing, global history, mispredict
// redirect and saturating statistics around a PHT of saturating counters.
module branch_pred_gshare
    import bp_pkg::*;
#(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned IDX_BITS     = 4,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned HIST_BITS    = 0,
    parameter int unsigned STAT_WID     = 16,
    localparam int unsigned GHR_W       = hist_width(HIST_BITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    // IF/ID lookup
    input  logic                    lookup_valid,
    input  logic [PROG_CTR_WID-1:0] lookup_pc,
    input  logic [PROG_CTR_WID-1:0] lookup_target,
    output logic                    pred_taken,
    output logic [PROG_CTR_WID-1:0] pred_nxt_prog_ctr,
    output logic [GHR_W-1:0]        lookup_ghr,
    // EX resolution
    input  logic                    resolve_valid,
    input  logic [PROG_CTR_WID-1:0] resolve_pc,
    input  logic [PROG_CTR_WID-1:0] resolve_target,
    input  logic                    resolve_taken,
    input  logic                    resolve_pred_taken,
    input  logic [GHR_W-1:0]        resolve_ghr,
    // Redirect and statistics
    output logic                    flush,
    output logic [PROG_CTR_WID-1:0] redirect_prog_ctr,
    output logic [STAT_WID-1:0]     branch_count,
    output logic [STAT_WID-1:0]     mispredict_count
);

    // With no history the XOR term is masked away entirely.
    localparam logic [IDX_BITS-1:0] HIST_MASK = (HIST_BITS == 0) ? '0 : '1;
    localparam logic [STAT_WID-1:0] STAT_MAX  = '1;

    logic [GHR_W-1:0]        ghr_q, ghr_d;
    logic                    flush_q, flush_d;
    logic [PROG_CTR_WID-1:0] redirect_q, redirect_d;
    logic [STAT_WID-1:0]     branch_cnt_q, branch_cnt_d;
    logic [STAT_WID-1:0]     mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0]     look_idx;
    logic [IDX_BITS-1:0]     upd_idx;
    logic [CTR_BITS-1:0]     look_ctr;
    logic                    mispredict;

    // PHT index hashing for both ports.
    always_comb begin
        look_idx = lookup_pc[IDX_BITS-1:0] ^ (IDX_BITS'(ghr_q) & HIST_MASK);
        upd_idx  = resolve_pc[IDX_BITS-1:0] ^ (IDX_BITS'(resolve_ghr) & HIST_MASK);
    end

    bp_pht #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (look_idx),
        .rd_ctr   (look_ctr),
        .wr_en    (resolve_valid),
        .wr_idx   (upd_idx),
        .wr_taken (resolve_taken)
    );

    // Combinational prediction from current table state.
    always_comb begin
        pred_taken        = lookup_valid & look_ctr[CTR_BITS-1];
        pred_nxt_prog_ctr = pred_taken ? lookup_target : lookup_pc + 1'b1;
        lookup_ghr        = ghr_q;
    end

    assign mispredict = resolve_valid & (resolve_taken != resolve_pred_taken);

    // Next-state for history, redirect and statistics.
    always_comb begin
        ghr_d         = ghr_q;
        flush_d       = mispredict;
        redirect_d    = redirect_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (resolve_valid) begin
            // History is non-speculative: shifted only on resolution.
            if (HIST_BITS == 0) begin
                ghr_d = '0;
            end else begin
                ghr_d = GHR_W'({ghr_q, resolve_taken});
            end
            if (branch_cnt_q != STAT_MAX) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
        end

        if (mispredict) begin
            redirect_d = resolve_taken ? resolve_target : resolve_pc + 1'b1;
            if (mispred_cnt_q != STAT_MAX) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any resolve sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q         <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign flush             = flush_q;
    assign redirect_prog_ctr = redirect_q;
    assign branch_count      = branch_cnt_q;
    assign mispredict_count  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_gshare.sv
// Bench for branch_pred_gshare: a bimodal instance and a gshare instance
// (narrow statistics) share stimulus and are checked against a table model.
module tb_branch_pred_gshare;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv = 1'b0;
    logic [9:0] lpc = '0, ltgt = '0;
    logic       rv = 1'b0;
    logic [9:0] rpc = '0, rtgt = '0;
    logic       rt = 1'b0, rp = 1'b0;
    logic [3:0] rghr = '0;

    logic        pt0, fl0;
    logic [9:0]  nxt0, rd0;
    logic [0:0]  lg0;
    logic [15:0] bc0, mc0;
    logic        pt1, fl1;
    logic [9:0]  nxt1, rd1;
    logic [3:0]  lg1;
    logic [3:0]  bc1, mc1;

    int checks = 0;
    int failures = 0;

    // Model state: index 0 bimodal, index 1 gshare with 4-bit history.
    int pht [2][16];
    int ghr [2];
    int e_fl [2];
    int e_rd [2];
    int e_bc [2];
    int e_mc [2];
    int smax [2] = '{65535, 15};

    always #5 clk = ~clk;

    branch_pred_gshare #(
        .PROG_CTR_WID (10), .IDX_BITS (4), .CTR_BITS (2), .HIST_BITS (0), .STAT_WID (16)
    ) dut0 (
        .clk (clk), .reset (rst),
        .lookup_valid (lv), .lookup_pc (lpc), .lookup_target (ltgt),
        .pred_taken (pt0), .pred_nxt_prog_ctr (nxt0), .lookup_ghr (lg0),
        .resolve_valid (rv), .resolve_pc (rpc), .resolve_target (rtgt),
        .resolve_taken (rt), .resolve_pred_taken (rp), .resolve_ghr (rghr[0:0]),
        .flush (fl0), .redirect_prog_ctr (rd0),
        .branch_count (bc0), .mispredict_count (mc0)
    );

    branch_pred_gshare #(
        .PROG_CTR_WID (10), .IDX_BITS (4), .CTR_BITS (2), .HIST_BITS (4), .STAT_WID (4)
    ) dut1 (
        .clk (clk), .reset (rst),
        .lookup_valid (lv), .lookup_pc (lpc), .lookup_target (ltgt),
        .pred_taken (pt1), .pred_nxt_prog_ctr (nxt1), .lookup_ghr (lg1),
        .resolve_valid (rv), .resolve_pc (rpc), .resolve_target (rtgt),
        .resolve_taken (rt), .resolve_pred_taken (rp), .resolve_ghr (rghr),
        .flush (fl1), .redirect_prog_ctr (rd1),
        .branch_count (bc1), .mispredict_count (mc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) pht[k][i] = 1;
            ghr[k] = 0; e_fl[k] = 0; e_rd[k] = 0; e_bc[k] = 0; e_mc[k] = 0;
        end
    endtask

    function automatic int e_pt(int k);
        int idx;
        idx = (int'(lpc) % 16) ^ ghr[k];
        return (lv && pht[k][idx] >= 2) ? 1 : 0;
    endfunction

    function automatic int e_nxt(int k);
        return (e_pt(k) != 0) ? int'(ltgt) : (int'(lpc) + 1) % 1024;
    endfunction

    // Apply the architectural effect of one clock edge with the current inputs.
    task automatic model_update();
        int idx;
        bit mis;
        if (rst) begin
            model_reset();
            return;
        end
        mis = rv && (rt != rp);
        for (int k = 0; k < 2; k++) begin
            e_fl[k] = mis ? 1 : 0;
            if (mis) e_rd[k] = rt ? int'(rtgt) : (int'(rpc) + 1) % 1024;
            if (rv) begin
                idx = (int'(rpc) % 16) ^ ((k == 1) ? int'(rghr) : 0);
                if (rt) pht[k][idx] = (pht[k][idx] == 3) ? 3 : pht[k][idx] + 1;
                else    pht[k][idx] = (pht[k][idx] == 0) ? 0 : pht[k][idx] - 1;
                if (k == 1) ghr[k] = ((ghr[k] << 1) | int'(rt)) % 16;
                if (e_bc[k] < smax[k]) e_bc[k]++;
                if (mis && e_mc[k] < smax[k]) e_mc[k]++;
            end
        end
    endtask

    // One cycle: check lookup outputs, clock, then check registered outputs.
    task automatic step();
        #1;
        chk("pred_taken0", 32'(pt0), 32'(e_pt(0)));
        chk("pred_nxt0", 32'(nxt0), 32'(e_nxt(0)));
        chk("lookup_ghr0", 32'(lg0), 32'd0);
        chk("pred_taken1", 32'(pt1), 32'(e_pt(1)));
        chk("pred_nxt1", 32'(nxt1), 32'(e_nxt(1)));
        chk("lookup_ghr1", 32'(lg1), 32'(ghr[1]));
        @(posedge clk);
        #1;
        model_update();
        chk("flush0", 32'(fl0), 32'(e_fl[0]));
        chk("redirect0", 32'(rd0), 32'(e_rd[0]));
        chk("branch_cnt0", 32'(bc0), 32'(e_bc[0]));
        chk("mispred_cnt0", 32'(mc0), 32'(e_mc[0]));
        chk("flush1", 32'(fl1), 32'(e_fl[1]));
        chk("redirect1", 32'(rd1), 32'(e_rd[1]));
        chk("branch_cnt1", 32'(bc1), 32'(e_bc[1]));
        chk("mispred_cnt1", 32'(mc1), 32'(e_mc[1]));
    endtask

    function automatic logic [9:0] pick_pc();
        case ($urandom_range(0, 3))
            0: return 10'h005;
            1: return 10'h015;
            2: return 10'h3FF;
            default: return 10'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first lookup.
        lv = 1'b1; lpc = 10'h005; ltgt = 10'h040;
        #1;
        chk("rst_pred", 32'(pt0), 32'd0);
        chk("rst_nxt", 32'(nxt0), 32'h006);
        chk("rst_flush", 32'(fl0), 32'd0);
        chk("rst_bcnt", 32'(bc0), 32'd0);
        chk("rst_mcnt", 32'(mc0), 32'd0);
        step();

        // Taken mispredict, then a correct prediction, then a trained lookup.
        lv = 1'b0; rv = 1'b1; rpc = 10'h005; rt = 1'b1; rp = 1'b0; rtgt = 10'h040; rghr = 4'h0;
        step();
        chk("mp_flush", 32'(fl0), 32'd1);
        chk("mp_redirect", 32'(rd0), 32'h040);
        chk("mp_mcnt", 32'(mc0), 32'd1);
        rp = 1'b1;
        step();
        chk("ok_flush", 32'(fl0), 32'd0);
        rv = 1'b0; lv = 1'b1; lpc = 10'h005; ltgt = 10'h040;
        #1;
        chk("trained_pred", 32'(pt0), 32'd1);
        chk("trained_nxt", 32'(nxt0), 32'h040);
        step();

        // Saturation: five taken then one not-taken.
        rst = 1'b1; lv = 1'b0;
        step();
        rst = 1'b0; rv = 1'b1; rpc = 10'h005; rt = 1'b1; rp = 1'b1;
        repeat (5) step();
        rt = 1'b0;
        step();
        rv = 1'b0; lv = 1'b1; lpc = 10'h005;
        #1;
        chk("sat_pred", 32'(pt0), 32'd1);
        chk("sat_bcnt", 32'(bc0), 32'd6);
        step();

        // Aliasing; gshare trains idx 4, history drained back to zero elsewhere.
        rst = 1'b1; lv = 1'b0;
        step();
        rst = 1'b0; rv = 1'b1; rpc = 10'h005; rt = 1'b1; rp = 1'b0; rghr = 4'h1;
        repeat (2) step();
        rpc = 10'h00A; rt = 1'b0; rp = 1'b0; rghr = 4'h0;
        repeat (4) step();
        rv = 1'b0; lv = 1'b1; lpc = 10'h015; ltgt = 10'h080;
        #1;
        chk("alias_bimodal", 32'(pt0), 32'd1);
        lpc = 10'h004;
        #1;
        chk("alias_gshare", 32'(pt1), 32'd1);
        chk("alias_gshare_ghr", 32'(lg1), 32'd0);
        chk("alias_bimodal_idx4", 32'(pt0), 32'd0);
        step();

        // PC wrap on fall-through and on not-taken redirect.
        lpc = 10'h3FF;
        #1;
        chk("wrap_pred", 32'(pt0), 32'd0);
        chk("wrap_nxt", 32'(nxt0), 32'h000);
        rv = 1'b1; rpc = 10'h3FF; rt = 1'b0; rp = 1'b1; rtgt = 10'h123;
        step();
        chk("wrap_flush", 32'(fl0), 32'd1);
        chk("wrap_redirect", 32'(rd0), 32'h000);

        // Back-to-back mispredicts, then redirect holds.
        rpc = 10'h020; rt = 1'b1; rp = 1'b0; rtgt = 10'h111;
        step();
        chk("b2b_flush_a", 32'(fl0), 32'd1);
        chk("b2b_redir_a", 32'(rd0), 32'h111);
        rpc = 10'h021; rt = 1'b0; rp = 1'b1;
        step();
        chk("b2b_flush_b", 32'(fl0), 32'd1);
        chk("b2b_redir_b", 32'(rd0), 32'h022);
        rv = 1'b0;
        step();
        chk("b2b_flush_end", 32'(fl0), 32'd0);
        chk("b2b_redir_hold", 32'(rd0), 32'h022);

        // Same-index lookup and resolve: lookup sees the old counter.
        rst = 1'b1;
        step();
        rst = 1'b0; lv = 1'b1; lpc = 10'h005; ltgt = 10'h040;
        rv = 1'b1; rpc = 10'h005; rt = 1'b1; rp = 1'b0; rghr = 4'h0;
        #1;
        chk("same_idx_pre", 32'(pt0), 32'd0);
        step();
        rv = 1'b0;
        #1;
        chk("same_idx_post", 32'(pt0), 32'd1);

        // Reset coincident with a mispredicting resolve.
        rst = 1'b1; rv = 1'b1; rpc = 10'h005; rt = 1'b0; rp = 1'b1;
        step();
        rst = 1'b0; rv = 1'b0;
        chk("rstdom_flush", 32'(fl0), 32'd0);
        chk("rstdom_mcnt", 32'(mc0), 32'd0);
        chk("rstdom_bcnt", 32'(bc0), 32'd0);
        lv = 1'b1; lpc = 10'h005;
        #1;
        chk("rstdom_pred", 32'(pt0), 32'd0);
        step();

        // Randomised traffic, including occasional reset and counter saturation.
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            lv   = 1'($urandom_range(0, 1));
            lpc  = pick_pc();
            ltgt = 10'($urandom_range(0, 1023));
            rv   = ($urandom_range(0, 3) != 0);
            rpc  = pick_pc();
            rtgt = 10'($urandom_range(0, 1023));
            rt   = 1'($urandom_range(0, 1));
            rp   = 1'($urandom_range(0, 1));
            rghr = ($urandom_range(0, 1) == 1) ? 4'(ghr[1]) : 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
